// File: rtl/time_pkg.sv
// Shared types for the mm:ss time datapath: packed BCD time, display-source
// encoding and the blank display pattern.
package time_pkg;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  typedef enum logic [1:0] {
    SEL_LIVE     = 2'd0,
    SEL_SAVED    = 2'd1,
    SEL_BLANK    = 2'd2,
    SEL_LIVE_ALT = 2'd3
  } out_sel_e;

  localparam logic [15:0] DISP_BLANK = 16'hFFFF;
  localparam bcd_time_t   TIME_ZERO  = '0;

  // True when one more decrement lands on (or stays at) 00:00.
  function automatic logic at_most_one_sec(bcd_time_t t);
    return (t.min_tens == 4'd0) && (t.min_ones == 4'd0) &&
           (t.sec_tens == 4'd0) && (t.sec_ones <= 4'd1);
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit counting modulo MODULUS with ripple carry/borrow outputs.
// clr beats ld beats inc/dec; inc and dec together hold the digit.
module bcd_digit_cnt #(
  parameter int unsigned MODULUS = 10
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] value,
  output logic       carry,
  output logic       borrow
);

  localparam logic [3:0] MAX_VAL = 4'(MODULUS - 1);

  logic [3:0] value_q;
  logic [3:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (ld) begin
      value_d = ld_val;
    end else if (inc && !dec) begin
      value_d = (value_q == MAX_VAL) ? 4'd0 : value_q + 4'd1;
    end else if (dec && !inc) begin
      value_d = (value_q == 4'd0) ? MAX_VAL : value_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value  = value_q;
  assign carry  = inc && !dec && (value_q == MAX_VAL);
  assign borrow = dec && !inc && (value_q == 4'd0);

endmodule

// File: rtl/time_datapath.sv
// Stopwatch/timer datapath: prescaled second tick, four-digit BCD mm:ss count,
// sticky expiry flag. Define TIME_SAVE_REG_EN to build the saved register.
module time_datapath
  import time_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        clear,
  input  logic        enable,
  input  logic        enable_increment,
  input  logic        enable_decrement,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  output_select,
  output logic        flag,
  output logic [15:0] disp
);

  localparam int unsigned    PW         = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          flag_q, flag_d;
  logic          tick;
  logic          up_req, dn_req;
  logic          load;
  logic          cnt_hold;
  logic          inc0, dec0;
  bcd_time_t     live;
  bcd_time_t     saved_val;

  logic [3:0] s1_val, s10_val, m1_val, m10_val;
  logic       s1_carry, s10_carry, m1_carry, m10_carry;
  logic       s1_borrow, s10_borrow, m1_borrow, m10_borrow;
  logic       unused_top_ripple;

  // Prescaler: runs only while enabled, wraps on the tick cycle.
  assign tick = enable && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (enable) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  // Counting with enable low is the setup step-up path, one second per cycle.
  assign up_req   = enable_increment && !enable_decrement && (tick || !enable);
  assign dn_req   = enable_decrement && !enable_increment && tick;
  assign cnt_hold = clear || load;
  assign inc0     = up_req && !cnt_hold;
  assign dec0     = dn_req && !cnt_hold && (live != TIME_ZERO);

  always_comb begin
    flag_d = flag_q;
    if (clear) begin
      flag_d = 1'b0;
    end else if (dn_req && !load && at_most_one_sec(live)) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      presc_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      flag_q  <= flag_d;
    end
  end

`ifdef TIME_SAVE_REG_EN
  bcd_time_t saved_q;

  // write captures the pre-edge live value even when clear or read also fire.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      saved_q <= TIME_ZERO;
    end else if (write) begin
      saved_q <= live;
    end
  end

  assign saved_val = saved_q;
  assign load      = read && !clear;
`else
  logic unused_save_ports;

  assign saved_val         = TIME_ZERO;
  assign load              = 1'b0;
  assign unused_save_ports = write ^ read;
`endif

  bcd_digit_cnt #(.MODULUS(10)) u_sec_ones (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (clear),
    .ld     (load),
    .ld_val (saved_val.sec_ones),
    .inc    (inc0),
    .dec    (dec0),
    .value  (s1_val),
    .carry  (s1_carry),
    .borrow (s1_borrow)
  );

  bcd_digit_cnt #(.MODULUS(6)) u_sec_tens (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (clear),
    .ld     (load),
    .ld_val (saved_val.sec_tens),
    .inc    (s1_carry),
    .dec    (s1_borrow),
    .value  (s10_val),
    .carry  (s10_carry),
    .borrow (s10_borrow)
  );

  bcd_digit_cnt #(.MODULUS(10)) u_min_ones (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (clear),
    .ld     (load),
    .ld_val (saved_val.min_ones),
    .inc    (s10_carry),
    .dec    (s10_borrow),
    .value  (m1_val),
    .carry  (m1_carry),
    .borrow (m1_borrow)
  );

  bcd_digit_cnt #(.MODULUS(6)) u_min_tens (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (clear),
    .ld     (load),
    .ld_val (saved_val.min_tens),
    .inc    (m1_carry),
    .dec    (m1_borrow),
    .value  (m10_val),
    .carry  (m10_carry),
    .borrow (m10_borrow)
  );

  // 59:59 rolls over naturally; underflow is blocked upstream, so the top
  // ripple outputs carry no information.
  assign unused_top_ripple = m10_carry | m10_borrow;

  assign live = {m10_val, m1_val, s10_val, s1_val};
  assign flag = flag_q;

  always_comb begin
    disp = live;
    case (out_sel_e'(output_select))
      SEL_LIVE, SEL_LIVE_ALT: disp = live;
      SEL_SAVED:              disp = saved_val;
      SEL_BLANK:              disp = DISP_BLANK;
      default:                disp = live;
    endcase
  end

endmodule

// File: tb/tb_time_datapath.sv
// Bench for time_datapath with TICKS_PER_SEC=4: a seconds-based model, a
// per-cycle compare process, directed scenarios and a randomized phase.
`timescale 1ns/1ps
module tb_time_datapath;

  localparam int T = 4;
`ifdef TIME_SAVE_REG_EN
  localparam bit SAVE_EN = 1'b1;
`else
  localparam bit SAVE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        clear = 1'b0;
  logic        enable = 1'b0;
  logic        enable_increment = 1'b0;
  logic        enable_decrement = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [1:0]  output_select = 2'd0;
  logic        flag;
  logic [15:0] disp;

  time_datapath #(.TICKS_PER_SEC(T)) dut (
    .clk              (clk),
    .nrst             (nrst),
    .clear            (clear),
    .enable           (enable),
    .enable_increment (enable_increment),
    .enable_decrement (enable_decrement),
    .write            (write),
    .read             (read),
    .output_select    (output_select),
    .flag             (flag),
    .disp             (disp)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // model state: live and saved counts in whole seconds, prescaler phase
  int m_live  = 0;
  int m_saved = 0;
  int m_presc = 0;
  bit m_flag  = 1'b0;

  function automatic logic [15:0] to_bcd(input int s);
    int mm;
    int ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] model_disp();
    case (output_select)
      2'd1:    return SAVE_EN ? to_bcd(m_saved) : 16'h0000;
      2'd2:    return 16'hFFFF;
      default: return to_bcd(m_live);
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: advance one clock edge, stepping the model from the current inputs
  task automatic cycle();
    int n_live, n_saved, n_presc;
    bit n_flag, tick, up, dn;
    n_live  = m_live;
    n_saved = m_saved;
    n_flag  = m_flag;
    tick    = enable && (m_presc == T - 1);
    n_presc = clear ? 0 : (enable ? (m_presc + 1) % T : m_presc);
    up      = enable_increment && !enable_decrement && (tick || !enable);
    dn      = enable_decrement && !enable_increment && tick;
    if (clear) begin
      n_live = 0;
      n_flag = 1'b0;
    end else if (read && SAVE_EN) begin
      n_live = m_saved;
    end else if (up) begin
      n_live = (m_live + 1) % 3600;
    end else if (dn) begin
      n_live = (m_live > 0) ? m_live - 1 : 0;
      if (n_live == 0) n_flag = 1'b1;
    end
    if (write && SAVE_EN) n_saved = m_live;
    @(posedge clk);
    if (nrst) begin
      m_live  = n_live;
      m_saved = n_saved;
      m_presc = n_presc;
      m_flag  = n_flag;
    end
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic assert_reset();
    nrst    = 1'b0;
    m_live  = 0;
    m_saved = 0;
    m_presc = 0;
    m_flag  = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0; enable = 1'b0; enable_increment = 1'b0; enable_decrement = 1'b0;
    write = 1'b0; read = 1'b0; output_select = 2'd0;
  endtask

  task automatic lit(input string name, input logic [15:0] exp);
    check({name, "_disp"}, disp, exp);
    check({name, "_model"}, model_disp(), exp);
  endtask

  // scoreboard compare: every cycle, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_disp", disp, model_disp());
      check("cyc_flag", {15'd0, flag}, {15'd0, m_flag});
    end
  end

  initial begin
    assert_reset();
    #12;
    check("reset_disp", disp, 16'h0000);
    check("reset_flag", {15'd0, flag}, 16'h0000);
    release_reset();
    cmp_en = 1'b1;

    // count up two seconds
    enable = 1'b1; enable_increment = 1'b1;
    cycles(8);
    lit("up8", 16'h0002);
    check("up8_flag", {15'd0, flag}, 16'h0000);

    // save 00:02, reload it, then count down to expiry and past it
    enable = 1'b0; enable_increment = 1'b0;
    write = 1'b1; cycle(); write = 1'b0;
    read = 1'b1; cycle(); read = 1'b0;
    lit("reload", 16'h0002);
    enable = 1'b1; enable_decrement = 1'b1;
    cycles(7);
    lit("dn7", 16'h0001);
    check("dn7_flag", {15'd0, flag}, 16'h0000);
    cycle();
    lit("dn8", 16'h0000);
    check("dn8_flag", {15'd0, flag}, 16'h0001);
    cycles(4);
    lit("dn_hold", 16'h0000);
    check("dn_hold_flag", {15'd0, flag}, 16'h0001);

    // setup-mode walk to 59:59, then one increment tick wraps to 00:00
    idle_inputs();
    clear = 1'b1; cycle(); clear = 1'b0;
    enable_increment = 1'b1;
    cycles(3599);
    lit("max", 16'h5959);
    enable = 1'b1;
    cycles(3);
    lit("max_pre", 16'h5959);
    cycle();
    lit("wrap", 16'h0000);
    check("wrap_flag", {15'd0, flag}, 16'h0000);

    // 01:30 saved, cleared, viewed and reloaded
    idle_inputs();
    clear = 1'b1; cycle(); clear = 1'b0;
    enable_increment = 1'b1;
    cycles(90);
    lit("set130", 16'h0130);
    enable_increment = 1'b0;
    write = 1'b1; cycle(); write = 1'b0;
    clear = 1'b1; cycle(); clear = 1'b0;
    output_select = 2'd1; #1;
    lit("saved_view", SAVE_EN ? 16'h0130 : 16'h0000);
    output_select = 2'd0; #1;
    lit("live_cleared", 16'h0000);
    output_select = 2'd3; #1;
    lit("live_alt", 16'h0000);
    output_select = 2'd0;
    read = 1'b1; cycle(); read = 1'b0;
    lit("read130", SAVE_EN ? 16'h0130 : 16'h0000);

    // single-cycle step pulses, then inc+dec together during ticks
    idle_inputs();
    clear = 1'b1; cycle(); clear = 1'b0;
    enable_increment = 1'b1;
    cycles(9);
    lit("set009", 16'h0009);
    for (int i = 0; i < 3; i++) begin
      enable_increment = 1'b1; cycle();
      enable_increment = 1'b0; cycle();
    end
    lit("pulse3", 16'h0012);
    enable = 1'b1; enable_increment = 1'b1; enable_decrement = 1'b1;
    cycles(8);
    lit("both", 16'h0012);

    // expire a timer, leave partial prescaler progress, reset asynchronously
    idle_inputs();
    clear = 1'b1; cycle(); clear = 1'b0;
    enable_increment = 1'b1; cycle(); enable_increment = 1'b0;
    enable = 1'b1; enable_decrement = 1'b1;
    cycles(4);
    check("pre_rst_flag", {15'd0, flag}, 16'h0001);
    cycles(2);
    #2;
    assert_reset();
    #1;
    lit("async_rst", 16'h0000);
    check("async_rst_flag", {15'd0, flag}, 16'h0000);
    output_select = 2'd2; #1;
    lit("blank", 16'hFFFF);
    output_select = 2'd0;
    release_reset();
    enable_decrement = 1'b0; enable_increment = 1'b1;
    cycles(3);
    lit("post_rst3", 16'h0000);
    cycle();
    lit("post_rst4", 16'h0001);

    // randomized phase
    idle_inputs();
    for (int i = 0; i < 3000; i++) begin
      enable           = ($urandom_range(0, 3) != 0);
      enable_increment = $urandom_range(0, 1) == 1;
      enable_decrement = $urandom_range(0, 1) == 1;
      clear            = ($urandom_range(0, 49) == 0);
      write            = ($urandom_range(0, 15) == 0);
      read             = ($urandom_range(0, 15) == 0);
      output_select    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) begin
        #2;
        assert_reset();
        release_reset();
      end else begin
        cycle();
      end
    end

    idle_inputs();
    cycles(2);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
